uart_rx_param: RTL
==================

Name: uart_rx_param

Overview:
- Parametrised UART receiver; successor to the fixed 8N1, 16-clocks-per-bit receiver.
- Adds:
  - configurable data width, parity and stop bits
  - 3-sample majority voting and false-start rejection
  - valid/ready output holding register
  - parity, framing, overrun and break error reporting
- Sits between the serial input pad (via an internal synchroniser) and the byte-stream consumer (command parser/FIFO).

Parameters:
- CLKS_PER_BIT, 16: sys_clk cycles per serial bit. Must be ≥ 8.
- DATA_BITS, 8: data bits per frame. Legal range 5..9. Transmitted LSB first.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.

Ports:
- sys_clk, input, 1: system clock. All logic is on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- Rx, input, 1: asynchronous serial line. Idles high.
- rx_data, output, DATA_BITS: received word. Bit 0 is the first data bit received.
- rx_valid, output, 1: rx_data and the error flags are valid. Held until accepted.
- rx_ready, input, 1: consumer accepts the word when rx_valid && rx_ready at a clock edge.
- parity_err, output, 1: parity mismatch for the held word. Always 0 when PARITY = 0.
- frame_err, output, 1: one or more stop bits sampled low for the held word.
- break_det, output, 1: held word has all data bits 0, parity bit 0 (if present) and frame_err = 1.
- overrun_err, output, 1: single-cycle pulse when a completed frame is dropped.

Behaviour:
- Synchroniser and edge detection:
  - Rx passes through a 2-flop synchroniser; the sync flops reset to 1.
  - A falling edge is detected on the synchronised signal (previous = 1, current = 0).
- Bit counter:
  - Counts 0..CLKS_PER_BIT-1 within each bit.
  - Sample points are M-1, M and M+1, where M = CLKS_PER_BIT/2 (integer division).
  - Bit value is the majority of the 3 samples, decided at M+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on a falling edge, go to START with the counter cleared. Otherwise stay.
  - START: at M+1, if the majority is 1 it is a false start; go to IDLE with no output. If 0, continue. At CLKS_PER_BIT-1, go to DATA with bit index 0.
  - DATA: at M+1, shift the majority into the bit at the current index. After DATA_BITS bits, go to PARITY if PARITY ≠ 0, otherwise go to STOP.
  - PARITY: at M+1, capture the parity bit. At CLKS_PER_BIT-1, go to STOP.
  - STOP: at M+1 of each stop bit, OR (!majority) into the frame error. At M+1 of the final stop bit, complete the frame and go straight to IDLE so a start edge in the second half of the stop bit is accepted.
- Parity check:
  - Odd: the data bits XOR parity bit must be 1.
  - Even: the data bits XOR parity bit must be 0.
- Frame completion, decided at the sample-complete edge. Results are visible on the next edge:
  - If rx_valid = 0, or rx_valid && rx_ready in the same cycle: load rx_data and all error flags, and set rx_valid = 1.
  - Otherwise (still holding an unaccepted word): drop the new word, keep the held word and flags unchanged, and pulse overrun_err high for 1 cycle.
- Handshake:
  - rx_valid clears on the edge where rx_valid && rx_ready, unless a new frame loads in that same cycle.
  - rx_data and the flags are stable while rx_valid = 1.
- Latency: a start edge on Rx reaches the FSM after 2 sync cycles plus 1 edge-detect cycle.
- Reset:
  - rx_data = 0, rx_valid = 0, all error flags = 0, FSM in IDLE, counters = 0, sync flops = 1.
  - A reset mid-frame discards the partial frame. After reset the block waits for a fresh falling edge; a line already low is not a start.
- Line held low indefinitely:
  - Produces one frame with break_det = 1, then the FSM stays in IDLE until a high followed by a new falling edge.
- Glitches: any low pulse shorter than about CLKS_PER_BIT/2 is rejected as a false start.

Test Plan:
- Defaults, reset = 1 for 2 cycles, then frame 0x8B (bits LSB-first 1,1,0,1,0,0,0,1, stop 1) at 16 clocks per bit, rx_ready = 1 → rx_valid for exactly 1 cycle, rx_data = 0x8B, all flags 0.
- PARITY = 2, DATA_BITS = 7:
  - Frame 0x55 with parity bit 0 → rx_data = 0x55, parity_err = 0.
  - Same frame with parity bit 1 → parity_err = 1.
- Stop bit driven 0 on frame 0x3C → frame_err = 1, rx_data = 0x3C. Line held low for 12 bit times → break_det = 1, and only one frame is produced.
- 4-cycle low glitch on an idle line → no rx_valid; the FSM returns to IDLE. Flip one of the 3 samples in a data bit → the majority recovers the correct data.
- rx_ready = 0, two back-to-back frames 0x11 then 0x22 → rx_data stays 0x11, overrun_err pulses 1 cycle. Then raise rx_ready → 0x11 is accepted and rx_valid drops.
- Assert reset in the middle of the DATA state of frame 0xA5, then send 0x5A → only 0x5A is reported, with no errors.

Source files
------------

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchronised, majority-voted serial input with
// configurable data/parity/stop format and a valid/ready holding register.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 sys_clk,
    input  logic                 reset,
    input  logic                 Rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] C_SAMP0 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] C_SAMP1 = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] C_DECIDE = CW'(CLKS_PER_BIT / 2 + 1);
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] C_LAST_BIT = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic                 r_sync1, r_sync2, r_prev;
    logic [1:0]           r_fill;
    state_t               r_state, w_next_state;
    logic [CW-1:0]        r_cnt;
    logic [IW-1:0]        r_bit_idx;
    logic                 r_stop_idx;
    logic [1:0]           r_samp;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bit;
    logic                 r_ferr_acc;

    logic w_fall, w_decide, w_end, w_maj, w_last_stop;
    logic w_bit_adv, w_stop_adv, w_complete;
    logic w_ferr_final, w_par_err, w_break;

    // r_prev only follows the line once the sync chain holds real samples, so
    // a line that is already low when reset releases never looks like a start.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_fill  <= 2'b00;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= Rx;
            r_sync2 <= r_sync1;
            r_fill  <= {r_fill[0], 1'b1};
            r_prev  <= r_fill[1] & r_sync2;
        end
    end

    assign w_fall      = r_prev & ~r_sync2;
    assign w_decide    = (r_cnt == C_DECIDE);
    assign w_end       = (r_cnt == C_LAST);
    assign w_maj       = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_sync2) | (r_samp[1] & r_sync2);
    assign w_last_stop = (STOP_BITS == 1) || r_stop_idx;

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_bit_adv    = 1'b0;
        w_stop_adv   = 1'b0;
        w_complete   = 1'b0;
        unique case (r_state)
            S_IDLE: if (w_fall) w_next_state = S_START;
            S_START: begin
                if (w_decide && w_maj) w_next_state = S_IDLE;
                else if (w_end)        w_next_state = S_DATA;
            end
            S_DATA: begin
                if (w_end) begin
                    if (r_bit_idx == C_LAST_BIT) w_next_state = (PARITY != 0) ? S_PARITY : S_STOP;
                    else                         w_bit_adv = 1'b1;
                end
            end
            S_PARITY: if (w_end) w_next_state = S_STOP;
            S_STOP: begin
                if (w_decide && w_last_stop) begin
                    w_complete   = 1'b1;
                    w_next_state = S_IDLE;
                end else if (w_end) begin
                    w_stop_adv = 1'b1;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_samp     <= 2'b11;
            r_shift    <= '0;
            r_par_bit  <= 1'b0;
            r_ferr_acc <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_cnt      <= (r_state == S_IDLE || w_end) ? '0 : r_cnt + 1'b1;
            r_stop_idx <= (r_state == S_STOP) ? (r_stop_idx | w_stop_adv) : 1'b0;
            if (r_state == S_START)  r_bit_idx <= '0;
            else if (w_bit_adv)      r_bit_idx <= r_bit_idx + 1'b1;
            if (r_cnt == C_SAMP0)    r_samp[0] <= r_sync2;
            if (r_cnt == C_SAMP1)    r_samp[1] <= r_sync2;
            if (r_state == S_DATA && w_decide)   r_shift[r_bit_idx] <= w_maj;
            if (r_state == S_PARITY && w_decide) r_par_bit <= w_maj;
            if (r_state == S_START)                   r_ferr_acc <= 1'b0;
            else if (r_state == S_STOP && w_decide)   r_ferr_acc <= r_ferr_acc | ~w_maj;
        end
    end

    assign w_ferr_final = r_ferr_acc | ~w_maj;
    assign w_par_err    = (PARITY == 1) ? ~(^r_shift ^ r_par_bit) :
                          (PARITY == 2) ?  (^r_shift ^ r_par_bit) : 1'b0;
    assign w_break      = (r_shift == '0) && (PARITY == 0 || !r_par_bit) && w_ferr_final;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            break_det   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (w_complete) begin
                if (!rx_valid || rx_ready) begin
                    rx_data    <= r_shift;
                    parity_err <= w_par_err;
                    frame_err  <= w_ferr_final;
                    break_det  <= w_break;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
